// File: rtl/reset_seq_pkg.sv
// Shared types and defaults for reset_sequencer.
package reset_seq_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK,
        COUNT,
        STAGE,
        RUN
    } state_t;

    localparam logic [31:0] DEFAULT_STARTUP_TIMEOUT = 32'h0000_FFFF;
    localparam logic [31:0] DEFAULT_STAGE_DELAY     = 32'h0000_0100;

    // Bits needed to hold 0..n-1, never narrower than one bit.
    function automatic int index_width(input int unsigned n);
        return (n <= 32'd2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/reset_sequencer.sv
// Staged multi-channel reset release gated by clock lock and a startup timeout.
// Define RESET_SEQ_LOCK_FILTER_EN to require LOCK_FILTER consecutive locked samples.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int unsigned NUM_CHANNELS    = 4,
    parameter int unsigned COUNT_WIDTH     = 32,
    parameter logic [31:0] STARTUP_TIMEOUT = DEFAULT_STARTUP_TIMEOUT,
    parameter logic [31:0] STAGE_DELAY     = DEFAULT_STAGE_DELAY,
    parameter int unsigned LOCK_FILTER     = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    locked,
    input  logic                    soft_rst_req,
    output logic [NUM_CHANNELS-1:0] startup_rst,
    output logic                    ready
);

    localparam int IDX_W = index_width(NUM_CHANNELS);

    localparam logic [COUNT_WIDTH-1:0]  TIMEOUT_LAST = COUNT_WIDTH'(STARTUP_TIMEOUT - 32'd1);
    localparam logic [COUNT_WIDTH-1:0]  STAGE_LAST   = COUNT_WIDTH'(STAGE_DELAY - 32'd1);
    localparam logic [IDX_W-1:0]        IDX_LAST     = IDX_W'(NUM_CHANNELS - 1);
    localparam logic [NUM_CHANNELS-1:0] CH_ONE       = NUM_CHANNELS'(1);

    // Declaration initialisers give the reset state at power-up without rst.
    state_t                   state     = WAIT_LOCK;
    logic [COUNT_WIDTH-1:0]   count     = '0;
    logic [IDX_W-1:0]         idx       = '0;
    logic [NUM_CHANNELS-1:0]  rst_q     = '1;
    logic                     ready_q   = 1'b0;

`ifdef RESET_SEQ_LOCK_FILTER_EN
    localparam int FILT_W = index_width(LOCK_FILTER);
    localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(LOCK_FILTER - 1);
    logic [FILT_W-1:0] filt = '0;
`else
    wire unused_lock_filter = (LOCK_FILTER != 0);
`endif

    wire abort = (state != WAIT_LOCK) && (!locked || soft_rst_req);

    always_ff @(posedge clk) begin
        if (rst || abort) begin
            state   <= WAIT_LOCK;
            count   <= '0;
            idx     <= '0;
            rst_q   <= '1;
            ready_q <= 1'b0;
`ifdef RESET_SEQ_LOCK_FILTER_EN
            filt    <= '0;
`endif
        end else begin
            unique case (state)
                WAIT_LOCK: begin
                    count <= '0;
`ifdef RESET_SEQ_LOCK_FILTER_EN
                    if (!locked || soft_rst_req) begin
                        filt <= '0;
                    end else if (filt == FILT_LAST) begin
                        filt  <= '0;
                        state <= COUNT;
                    end else begin
                        filt <= filt + FILT_W'(1);
                    end
`else
                    if (locked) begin
                        state <= COUNT;
                    end
`endif
                end
                COUNT: begin
                    if (count == TIMEOUT_LAST) begin
                        count    <= '0;
                        rst_q[0] <= 1'b0;
                        if (NUM_CHANNELS == 1) begin
                            state   <= RUN;
                            ready_q <= 1'b1;
                        end else begin
                            state <= STAGE;
                            idx   <= IDX_W'(1);
                        end
                    end else begin
                        count <= count + COUNT_WIDTH'(1);
                    end
                end
                STAGE: begin
                    if (count == STAGE_LAST) begin
                        count <= '0;
                        rst_q <= rst_q & ~(CH_ONE << idx);
                        // ready rises on the same edge as the final channel.
                        if (idx == IDX_LAST) begin
                            state   <= RUN;
                            ready_q <= 1'b1;
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end else begin
                        count <= count + COUNT_WIDTH'(1);
                    end
                end
                default: begin
                    count <= '0;
                end
            endcase
        end
    end

    assign startup_rst = rst_q;
    assign ready       = ready_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: 3 channels, timeout 16, stage delay 4.
module tb_reset_sequencer;

`ifdef RESET_SEQ_LOCK_FILTER_EN
    localparam int S = 7;   // 8 filtered lock samples replace the single one
`else
    localparam int S = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       locked = 1'b0;
    logic       soft_rst_req = 1'b0;
    logic [2:0] startup_rst;
    logic       ready;

    int vectors = 0;
    int miscompares = 0;

    reset_sequencer #(
        .NUM_CHANNELS   (3),
        .COUNT_WIDTH    (32),
        .STARTUP_TIMEOUT(32'd16),
        .STAGE_DELAY    (32'd4),
        .LOCK_FILTER    (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .locked      (locked),
        .soft_rst_req(soft_rst_req),
        .startup_rst (startup_rst),
        .ready       (ready)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected outputs at edge e when edge b is the first to sample locked high
    // in WAIT_LOCK: releases at b+16, b+20, b+24 (plus S with the lock filter).
    function automatic logic [2:0] exp_rst(input int e, input int b);
        int r;
        r = e - b + 1;
        if (r < 17 + S) return 3'b111;
        if (r < 21 + S) return 3'b110;
        if (r < 25 + S) return 3'b100;
        return 3'b000;
    endfunction

    task automatic do_reset();
        soft_rst_req = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_powerup();
        vectors++;
        if (startup_rst !== 3'b111 || ready !== 1'b0) begin
            miscompares++;
            $display("FAIL powerup: startup_rst=%b ready=%b, want 111/0", startup_rst, ready);
        end
    endtask

    task automatic test_reset();
        locked = 1'b1;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            vectors++;
            if (startup_rst !== 3'b111 || ready !== 1'b0) begin
                miscompares++;
                $display("FAIL reset cycle %0d: startup_rst=%b ready=%b, want 111/0", i, startup_rst, ready);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_locked_release();
        logic [2:0] e_rst;
        locked = 1'b1;
        do_reset();
        for (int e = 1; e <= 28 + S; e++) begin
            tick();
            e_rst = exp_rst(e, 1);
            vectors++;
            if (startup_rst !== e_rst || ready !== (e_rst == 3'b000)) begin
                miscompares++;
                $display("FAIL locked_release edge %0d: startup_rst=%b ready=%b, want %b/%b",
                         e, startup_rst, ready, e_rst, (e_rst == 3'b000));
            end
        end
    endtask

    task automatic test_late_lock();
        logic [2:0] e_rst;
        locked = 1'b0;
        do_reset();
        for (int e = 1; e <= 38 + S; e++) begin
            locked = (e >= 11);
            tick();
            e_rst = exp_rst(e, 11);
            vectors++;
            if (startup_rst !== e_rst || ready !== (e_rst == 3'b000)) begin
                miscompares++;
                $display("FAIL late_lock edge %0d: startup_rst=%b ready=%b, want %b/%b",
                         e, startup_rst, ready, e_rst, (e_rst == 3'b000));
            end
        end
    endtask

    task automatic test_lock_loss();
        logic [2:0] e_rst;
        int d;
        int r;
        d = 22 + S;
        r = 30 + S;
        locked = 1'b1;
        do_reset();
        for (int e = 1; e <= r + 26 + S; e++) begin
            locked = (e <= d) || (e >= r);
            tick();
            if (e <= d)     e_rst = exp_rst(e, 1);
            else if (e < r) e_rst = 3'b111;
            else            e_rst = exp_rst(e, r);
            vectors++;
            if (startup_rst !== e_rst || ready !== (e_rst == 3'b000)) begin
                miscompares++;
                $display("FAIL lock_loss edge %0d: startup_rst=%b ready=%b, want %b/%b",
                         e, startup_rst, ready, e_rst, (e_rst == 3'b000));
            end
        end
    endtask

    task automatic test_soft_rst();
        logic [2:0] e_rst;
        int p;
        p = 28 + S;
        locked = 1'b1;
        do_reset();
        for (int e = 1; e <= p + 27 + S; e++) begin
            soft_rst_req = (e == p);
            tick();
            e_rst = (e < p) ? exp_rst(e, 1) : exp_rst(e, p + 1);
            vectors++;
            if (startup_rst !== e_rst || ready !== (e_rst == 3'b000)) begin
                miscompares++;
                $display("FAIL soft_rst edge %0d: startup_rst=%b ready=%b, want %b/%b",
                         e, startup_rst, ready, e_rst, (e_rst == 3'b000));
            end
        end
        soft_rst_req = 1'b0;
    endtask

    // Pass 0: soft_rst_req and lock loss together on channel 1's release edge.
    // Pass 1: lock loss alone on channel 0's release edge.
    task automatic test_abort_on_release();
        logic [2:0] e_rst;
        int a;
        for (int pass = 0; pass < 2; pass++) begin
            a = (pass == 0) ? 21 + S : 17 + S;
            locked = 1'b1;
            do_reset();
            for (int e = 1; e <= a + 4; e++) begin
                soft_rst_req = (pass == 0) && (e == a);
                locked = (e != a);
                tick();
                e_rst = (e < a) ? exp_rst(e, 1) : exp_rst(e, a + 1);
                vectors++;
                if (startup_rst !== e_rst || ready !== (e_rst == 3'b000)) begin
                    miscompares++;
                    $display("FAIL abort_on_release pass %0d edge %0d: startup_rst=%b ready=%b, want %b/%b",
                             pass, e, startup_rst, ready, e_rst, (e_rst == 3'b000));
                end
            end
        end
        soft_rst_req = 1'b0;
        locked = 1'b1;
    endtask

    // Pattern 1,1,1,0 then steady 1; the final high run starts at edge 5.
    // Channel 0 releases at edge 21 unfiltered, edge 28 with the filter.
    task automatic test_lock_filter();
        logic [2:0] e_rst;
        locked = 1'b1;
        do_reset();
        for (int e = 1; e <= 36 + S; e++) begin
            locked = (e != 4);
            tick();
            e_rst = exp_rst(e, 5);
            vectors++;
            if (startup_rst !== e_rst || ready !== (e_rst == 3'b000)) begin
                miscompares++;
                $display("FAIL lock_filter edge %0d: startup_rst=%b ready=%b, want %b/%b",
                         e, startup_rst, ready, e_rst, (e_rst == 3'b000));
            end
        end
    endtask

    initial begin
        #1;
        test_powerup();
        test_reset();
        test_locked_release();
        test_late_lock();
        test_lock_loss();
        test_soft_rst();
        test_abort_on_release();
        test_lock_filter();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
